// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Target end of the single-cycle mem_req/mem_write interface.
//               Word-addressed storage with a fixed, parameterised read
//               latency, a built-in fill engine (mem[i] = i), wrapping
//               request counters and a sticky error flag.
// Ports       : clk, rst_n        - clock / async active-low reset
//               mem_req/mem_write - request strobe and direction
//               mem_addr/mem_wdata- word address / write data
//               mem_rdata_vld/mem_rdata - read return, LAT cycles after req
//               init_go/init_busy - start / progress of the pattern fill
//               err               - sticky: out-of-range or dropped request
//               rd_cnt/wr_cnt     - accepted in-range reads / writes
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int                MEM_AW   = 16,
    parameter int                MEM_DW   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                LAT      = 2,
    parameter int                CNT_W    = 16,
    parameter logic [MEM_DW-1:0] BAD_WORD = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    input  logic              init_go,
    output logic              init_busy,
    output logic              err,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int                 c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(DEPTH - 1);

    generate
        if (LAT < 1 || LAT > 8) begin : g_bad_lat
            $error("mem_responder: LAT must lie in 1..8");
        end
        if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << MEM_AW)) begin : g_bad_depth
            $error("mem_responder: DEPTH must lie in 1..2**MEM_AW");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_idx_w-1:0]  r_idx, w_idx_nxt;

    logic [MEM_DW-1:0]   r_mem [DEPTH];
    logic [LAT-1:0]      r_pipe_vld;
    logic [MEM_DW-1:0]   r_pipe_data [LAT];

    logic                w_busy;
    logic                w_in_range;
    logic                w_accept;
    logic                w_rd_issue;
    logic                w_rd_ok;
    logic                w_wr_ok;
    logic                w_err_set;
    logic [c_idx_w-1:0]  w_idx_addr;
    logic                w_we;
    logic [c_idx_w-1:0]  w_waddr;
    logic [MEM_DW-1:0]   w_wdata;
    logic [MEM_DW-1:0]   w_rd_data;

    // ------------------------------------------------------------------
    // Fill engine: IDLE and RUN behave identically for requests; RUN only
    // records that a fill has completed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (init_go) begin
                    w_state_nxt = ST_INIT;
                    w_idx_nxt   = '0;
                end
            end
            ST_INIT: begin
                // init_go is deliberately not looked at here
                if (r_idx == c_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_busy    = (r_state == ST_INIT);
    assign init_busy = w_busy;

    // ------------------------------------------------------------------
    // Request decode. Zero-extended compare so DEPTH == 2**MEM_AW works.
    // ------------------------------------------------------------------
    assign w_in_range = ({1'b0, mem_addr} < (MEM_AW + 1)'(DEPTH));
    assign w_accept   = mem_req & ~w_busy;
    assign w_rd_issue = w_accept & ~mem_write;      // out-of-range reads still return
    assign w_rd_ok    = w_rd_issue & w_in_range;
    assign w_wr_ok    = w_accept & mem_write & w_in_range;
    assign w_err_set  = mem_req & (w_busy | ~w_in_range);
    assign w_idx_addr = mem_addr[c_idx_w-1:0];

    // Single write port shared by the fill engine and the request path;
    // they never coincide because requests are dropped during the fill.
    assign w_we    = w_busy | w_wr_ok;
    assign w_waddr = w_busy ? r_idx : w_idx_addr;
    assign w_wdata = w_busy ? MEM_DW'(r_idx) : mem_wdata;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Data is captured at request time so later writes cannot disturb a
    // read already in flight.
    assign w_rd_data = w_in_range ? r_mem[w_idx_addr] : BAD_WORD;

    // ------------------------------------------------------------------
    // Read return pipeline: LAT capture/shift stages followed by the output
    // register, giving data visible after edge N+LAT for a request at N.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        r_pipe_data[0] <= w_rd_data;
        for (int i = 1; i < LAT; i++) begin
            r_pipe_data[i] <= r_pipe_data[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld    <= '0;
            mem_rdata_vld <= 1'b0;
            mem_rdata     <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_issue;
            for (int i = 1; i < LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
            mem_rdata_vld <= r_pipe_vld[LAT-1];
            if (r_pipe_vld[LAT-1]) begin
                mem_rdata <= r_pipe_data[LAT-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Status: counters wrap silently, err is sticky until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (w_rd_ok) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (w_wr_ok) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (w_err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
